// File: rtl/fifo_drain_pkg.sv
// Shared constants, state encoding and byte-order helpers for the FIFO drain serializer.
// Used by the serializer, its bus interface and the bench.
package fifo_drain_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_e;

    // Byte that goes on the wire next, given the current shift register contents.
    function automatic logic [BYTE_W-1:0] lead_byte(input logic [WORD_W-1:0] w,
                                                   input logic              msb_first);
        return msb_first ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w,
                                                    input logic              msb_first);
        return msb_first ? (w << BYTE_W) : (w >> BYTE_W);
    endfunction
endpackage

// File: rtl/fifo_drain_serializer_if.sv
// FIFO read port plus outgoing byte stream of the drain serializer.
// FIFO_DRAIN_PARITY_EN adds the out_parity signal.
interface fifo_drain_serializer_if;
    import fifo_drain_pkg::*;

    logic              fifo_on;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
`ifdef FIFO_DRAIN_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        input  fifo_on, fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last
`ifdef FIFO_DRAIN_PARITY_EN
        , output out_parity
`endif
    );

    modport slave (
        output fifo_on, fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last
`ifdef FIFO_DRAIN_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/fifo_drain_serializer.sv
// Pops 32-bit words from the FIFO and sends them as 4 bytes on a valid/ready stream (FIFO_DRAIN_PARITY_EN adds out_parity).
// Latency: first byte valid 3 cycles after IDLE sees data; 6 cycles per word at full rate.
// Backpressure: out_ready low holds the presented byte stable; no new pop until the last byte is accepted.
module fifo_drain_serializer
    import fifo_drain_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_drain_serializer_if.master bus,
    output logic                    busy,
    output logic [CNT_W-1:0]        words_done
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              accept;
    logic              more_work;

    assign accept    = out_valid_q & bus.out_ready;
    assign more_work = bus.fifo_on & ~bus.fifo_empty;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        words_d     = words_q;
        unique case (state_q)
            IDLE: begin
                if (more_work) state_d = REQ;
            end
            // The FIFO ignores rd_en while off, so nothing will arrive in that case.
            REQ: begin
                state_d = bus.fifo_on ? LOAD : IDLE;
            end
            LOAD: begin
                shreg_d     = bus.fifo_dout;
                idx_d       = '0;
                out_data_d  = lead_byte(bus.fifo_dout, MSB_FIRST);
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                state_d     = SEND;
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        words_d     = words_q + CNT_W'(1);
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = more_work ? REQ : IDLE;
                    end else begin
                        shreg_d    = shift_word(shreg_q, MSB_FIRST);
                        out_data_d = lead_byte(shreg_d, MSB_FIRST);
                        idx_d      = idx_q + IDX_W'(1);
                        out_last_d = (idx_q == LAST_IDX - IDX_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            words_q     <= words_d;
        end
    end

`ifdef FIFO_DRAIN_PARITY_EN
    logic out_parity_q;

    // Tracks out_data_d so parity changes in the same cycle as the byte it covers.
    always_ff @(posedge clk) begin
        if (!rst_n) out_parity_q <= 1'b0;
        else        out_parity_q <= ^out_data_d;
    end

    assign bus.out_parity = out_parity_q;
`endif

    assign bus.fifo_rd_en = (state_q == REQ);
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign busy           = (state_q != IDLE);
    assign words_done     = words_q;
endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one behavioural 8x32 FIFO.
// The counter is 4 bits wide so its wrap is reachable in a short run.
module tb_fifo_drain_serializer;
    import fifo_drain_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, fifo_on, hold, sel, ready, wr_en, fifo_clr;
    logic [31:0] wr_data;
    logic [31:0] mem [8];
    int          cnt, rptr, wptr;
    logic [31:0] dout;
    logic        fifo_empty, fifo_rd, do_wr, do_rd;
    logic        busy_m, busy_l;
    logic [CW-1:0] wd_m, wd_l;

    fifo_drain_serializer_if bus_m ();
    fifo_drain_serializer_if bus_l ();

    fifo_drain_serializer #(.MSB_FIRST(1'b1), .CNT_W(CW)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bus_m), .busy(busy_m), .words_done(wd_m));
    fifo_drain_serializer #(.MSB_FIRST(1'b0), .CNT_W(CW)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l), .busy(busy_l), .words_done(wd_l));

    assign fifo_empty       = (cnt == 0);
    assign bus_m.fifo_on    = fifo_on & ~sel;
    assign bus_m.fifo_empty = fifo_empty | hold | sel;
    assign bus_m.fifo_dout  = dout;
    assign bus_m.out_ready  = ready & ~sel;
    assign bus_l.fifo_on    = fifo_on & sel;
    assign bus_l.fifo_empty = fifo_empty | hold | ~sel;
    assign bus_l.fifo_dout  = dout;
    assign bus_l.out_ready  = ready & sel;
    assign fifo_rd          = sel ? bus_l.fifo_rd_en : bus_m.fifo_rd_en;
    assign do_wr            = wr_en & fifo_on & (cnt < 8);
    assign do_rd            = fifo_rd & fifo_on & (cnt != 0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            cnt  <= 0;
            rptr <= 0;
            wptr <= 0;
            dout <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wr_data;
                wptr      <= (wptr + 1) % 8;
            end
            if (do_rd) begin
                dout <= mem[rptr];
                rptr <= (rptr + 1) % 8;
            end
            cnt <= cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
        end
    end

    logic          obs_valid, obs_last, obs_busy, obs_par;
    logic [7:0]    obs_data;
    logic [CW-1:0] obs_wd;
    assign obs_valid = sel ? bus_l.out_valid : bus_m.out_valid;
    assign obs_last  = sel ? bus_l.out_last  : bus_m.out_last;
    assign obs_data  = sel ? bus_l.out_data  : bus_m.out_data;
    assign obs_busy  = sel ? busy_l : busy_m;
    assign obs_wd    = sel ? wd_l : wd_m;
`ifdef FIFO_DRAIN_PARITY_EN
    assign obs_par   = sel ? bus_l.out_parity : bus_m.out_parity;
`else
    assign obs_par   = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int words_m = 0;
    int words_l = 0;

    logic          s_valid, s_last, s_busy, s_par;
    logic [7:0]    s_data;
    logic [CW-1:0] s_wd;

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i, input bit msb);
        int sh;
        sh = msb ? 8 * (3 - i) : 8 * i;
        return 8'(w >> sh);
    endfunction

    // One clock: sample at the falling edge, return 1 ns after the rising edge.
    task automatic step(output bit acc, output bit rd);
        @(negedge clk);
        acc     = (obs_valid === 1'b1) && ready;
        rd      = (fifo_rd === 1'b1);
        s_valid = obs_valid;
        s_last  = obs_last;
        s_data  = obs_data;
        s_busy  = obs_busy;
        s_wd    = obs_wd;
        s_par   = obs_par;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_t e;
        bit   a, r;
        for (int i = 0; i < 4; i++) begin
            e.data = exp_byte(w, i, !sel);
            e.last = (i == 3);
            exp_q.push_back(e);
        end
        if (sel) words_l = (words_l + 1) % 16;
        else     words_m = (words_m + 1) % 16;
        wr_en   = 1'b1;
        wr_data = w;
        step(a, r);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        bit acc, rd;
        int npulse, first_rd;
        exp_t e;
        rst_n = 1'b0;
        push_word(32'h1122_3344);
        for (int i = 0; i < 2; i++) begin
            step(acc, rd);
            n_total++;
            if (rd || s_valid !== 1'b0 || s_wd !== '0 || s_busy !== 1'b0)
                $display("FAIL reset_state: rd=%0b valid=%b words=%0d busy=%b, want all 0", rd, s_valid, s_wd, s_busy);
            else n_pass++;
        end
        rst_n = 1'b1;
        npulse = 0;
        first_rd = -1;
        for (int i = 0; i < 12; i++) begin
            step(acc, rd);
            if (rd) begin
                npulse++;
                if (first_rd < 0) first_rd = i;
            end
            if (acc) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL reset_sb: unexpected byte %h", s_data);
                else begin
                    e = exp_q.pop_front();
                    if (s_data !== e.data || s_last !== e.last)
                        $display("FAIL reset_byte: got %h/%b want %h/%b", s_data, s_last, e.data, e.last);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (first_rd !== 1 || npulse !== 1)
            $display("FAIL reset_rd_pulse: first at %0d count %0d, want 1 and 1", first_rd, npulse);
        else n_pass++;
        n_total++;
        if (s_wd !== CW'(words_m)) $display("FAIL reset_words: got %0d want %0d", s_wd, words_m);
        else n_pass++;
    endtask

    task automatic test_single();
        bit acc, rd;
        int npulse, first_acc, last_acc;
        exp_t e;
        push_word(32'hA1B2_C3D4);
        npulse = 0;
        first_acc = -1;
        last_acc = -1;
        for (int i = 0; i < 14; i++) begin
            step(acc, rd);
            if (rd) npulse++;
            if (acc) begin
                if (first_acc < 0) first_acc = i;
                last_acc = i;
                n_total++;
                if (exp_q.size() == 0) $display("FAIL single_sb: unexpected byte %h", s_data);
                else begin
                    e = exp_q.pop_front();
                    if (s_data !== e.data || s_last !== e.last)
                        $display("FAIL single_byte: got %h/%b want %h/%b", s_data, s_last, e.data, e.last);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (last_acc - first_acc !== 3 || npulse !== 1)
            $display("FAIL single_timing: span %0d pulses %0d, want 3 and 1", last_acc - first_acc, npulse);
        else n_pass++;
        n_total++;
        if (s_wd !== CW'(words_m) || s_busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL single_end: words=%0d busy=%b left=%0d, want %0d 0 0", s_wd, s_busy, exp_q.size(), words_m);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit acc, rd;
        int npulse, nacc, stall;
        exp_t e;
        push_word(32'hA1B2_C3D4);
        npulse = 0;
        nacc = 0;
        stall = 0;
        for (int i = 0; i < 24; i++) begin
            step(acc, rd);
            if (rd) npulse++;
            if (acc) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL bp_sb: unexpected byte %h", s_data);
                else begin
                    e = exp_q.pop_front();
                    if (s_data !== e.data || s_last !== e.last)
                        $display("FAIL bp_byte: got %h/%b want %h/%b", s_data, s_last, e.data, e.last);
                    else n_pass++;
                end
                nacc++;
                if (nacc == 2) begin
                    stall = 5;
                    ready = 1'b0;
                end
            end else if (stall > 0) begin
                n_total++;
                if (s_valid !== 1'b1 || s_data !== 8'hC3 || s_last !== 1'b0)
                    $display("FAIL bp_hold: valid=%b data=%h last=%b, want 1 c3 0", s_valid, s_data, s_last);
                else n_pass++;
                stall--;
                if (stall == 0) ready = 1'b1;
            end
        end
        n_total++;
        if (npulse !== 1 || nacc !== 4 || s_wd !== CW'(words_m))
            $display("FAIL bp_end: pulses=%0d bytes=%0d words=%0d, want 1 4 %0d", npulse, nacc, s_wd, words_m);
        else n_pass++;
    endtask

    task automatic test_burst();
        bit acc, rd;
        int npulse, last_rd;
        exp_t e;
        sel = 1'b1;
        hold = 1'b1;
        for (int k = 0; k < 8; k++) push_word(32'(k));
        hold = 1'b0;
        npulse = 0;
        last_rd = -1;
        for (int i = 0; i < 70; i++) begin
            step(acc, rd);
            if (rd) begin
                if (last_rd >= 0) begin
                    n_total++;
                    if (i - last_rd !== 6) $display("FAIL burst_spacing: got %0d cycles want 6", i - last_rd);
                    else n_pass++;
                end
                last_rd = i;
                npulse++;
            end
            if (acc) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL burst_sb: unexpected byte %h", s_data);
                else begin
                    e = exp_q.pop_front();
                    if (s_data !== e.data || s_last !== e.last)
                        $display("FAIL burst_byte: got %h/%b want %h/%b", s_data, s_last, e.data, e.last);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (npulse !== 8 || s_wd !== CW'(words_l) || fifo_empty !== 1'b1 || exp_q.size() != 0)
            $display("FAIL burst_end: pulses=%0d words=%0d empty=%b left=%0d, want 8 %0d 1 0",
                     npulse, s_wd, fifo_empty, exp_q.size(), words_l);
        else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_on_req();
        bit acc, rd;
        int bad;
        exp_t e;
        push_word(32'h5566_7788);
        step(acc, rd);
        fifo_on = 1'b0;
        step(acc, rd);
        n_total++;
        if (!rd || s_busy !== 1'b1) $display("FAIL onreq_req: rd=%0b busy=%b, want 1 1", rd, s_busy);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(acc, rd);
            if (s_busy !== 1'b0 || s_valid !== 1'b0 || rd) bad++;
        end
        n_total++;
        if (bad != 0 || cnt != 1) $display("FAIL onreq_idle: bad cycles=%0d fifo count=%0d, want 0 1", bad, cnt);
        else n_pass++;
        fifo_on = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(acc, rd);
            if (acc) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL onreq_sb: unexpected byte %h", s_data);
                else begin
                    e = exp_q.pop_front();
                    if (s_data !== e.data || s_last !== e.last)
                        $display("FAIL onreq_byte: got %h/%b want %h/%b", s_data, s_last, e.data, e.last);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (s_wd !== CW'(words_m) || exp_q.size() != 0)
            $display("FAIL onreq_end: words=%0d left=%0d, want %0d 0", s_wd, exp_q.size(), words_m);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        bit acc, rd;
        int nacc, bad;
        exp_t e;
        push_word(32'hDEAD_BEEF);
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 2; i++) begin
            step(acc, rd);
            if (acc) begin
                nacc++;
                n_total++;
                e = exp_q.pop_front();
                if (s_data !== e.data) $display("FAIL midrst_byte: got %h want %h", s_data, e.data);
                else n_pass++;
            end
        end
        rst_n = 1'b0;
        ready = 1'b0;
        step(acc, rd);
        step(acc, rd);
        n_total++;
        if (s_valid !== 1'b0 || s_wd !== '0 || s_busy !== 1'b0)
            $display("FAIL midrst_state: valid=%b words=%0d busy=%b, want 0 0 0", s_valid, s_wd, s_busy);
        else n_pass++;
        exp_q.delete();
        words_m = 0;
        words_l = 0;
        rst_n = 1'b1;
        ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(acc, rd);
            if (s_valid !== 1'b0 || rd) bad++;
        end
        n_total++;
        if (bad != 0 || cnt != 0) $display("FAIL midrst_after: bad cycles=%0d fifo count=%0d, want 0 0", bad, cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit acc, rd;
        int n;
        exp_t e;
        for (int b = 0; b < 3; b++) begin
            n = (b == 0) ? 8 : (b == 1) ? 7 : 1;
            hold = 1'b1;
            for (int k = 0; k < n; k++) push_word($urandom);
            hold = 1'b0;
            for (int i = 0; i < 6 * n + 12; i++) begin
                step(acc, rd);
                if (acc) begin
                    n_total++;
                    if (exp_q.size() == 0) $display("FAIL wrap_sb: unexpected byte %h", s_data);
                    else begin
                        e = exp_q.pop_front();
                        if (s_data !== e.data || s_last !== e.last)
                            $display("FAIL wrap_byte: got %h/%b want %h/%b", s_data, s_last, e.data, e.last);
                        else n_pass++;
                    end
                end
            end
            n_total++;
            if (s_wd !== CW'(words_m)) $display("FAIL wrap_count: got %0d want %0d", s_wd, words_m);
            else n_pass++;
        end
        n_total++;
        if (s_wd !== '0) $display("FAIL wrap_zero: got %0d want 0", s_wd);
        else n_pass++;
    endtask

`ifdef FIFO_DRAIN_PARITY_EN
    task automatic test_parity();
        bit   acc, rd;
        int   k;
        logic par_tab [4];
        par_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
        push_word(32'h0103_0700);
        k = 0;
        for (int i = 0; i < 14; i++) begin
            step(acc, rd);
            if (acc && k < 4) begin
                void'(exp_q.pop_front());
                n_total++;
                if (s_par !== par_tab[k]) $display("FAIL parity_%0d: byte %h got %b want %b", k, s_data, s_par, par_tab[k]);
                else n_pass++;
                k++;
            end
        end
    endtask
`endif

    initial begin
        bit a, r;
        rst_n    = 1'b0;
        fifo_on  = 1'b1;
        hold     = 1'b0;
        sel      = 1'b0;
        ready    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        fifo_clr = 1'b1;
        step(a, r);
        step(a, r);
        fifo_clr = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_on_req();
`ifdef FIFO_DRAIN_PARITY_EN
        test_parity();
`endif
        test_reset_mid_send();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
